// File: rtl/mux_scan_sequencer_if.sv
// Bus between the scan sequencer and its environment: the start/stop/
// repeat controls, the select driven to the 32:1 mux, the mux's returned
// bit, and the serial output stream with its status flags.
// With SCAN_CAPTURE_EN defined the bus also carries the parallel capture
// word (cap) and its strobe (cap_valid).
interface mux_scan_sequencer_if;
    logic       start;
    logic       stop;
    logic       repeat_en;
    logic [4:0] sw;
    logic       bit_in;
    logic       bit_out;
    logic       bit_valid;
    logic       busy;
    logic       done;
`ifdef SCAN_CAPTURE_EN
    logic [31:0] cap;
    logic        cap_valid;

    modport master (
        output start, stop, repeat_en, bit_in,
        input  sw, bit_out, bit_valid, busy, done, cap, cap_valid
    );
    modport slave (
        input  start, stop, repeat_en, bit_in,
        output sw, bit_out, bit_valid, busy, done, cap, cap_valid
    );
`else
    modport master (
        output start, stop, repeat_en, bit_in,
        input  sw, bit_out, bit_valid, busy, done
    );
    modport slave (
        input  start, stop, repeat_en, bit_in,
        output sw, bit_out, bit_valid, busy, done
    );
`endif
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps the 5-bit select of a 32:1 bit mux from 0 to LAST, holding each
// index for TICK_DIV cycles, samples the returned bit in the last cycle of
// each dwell and emits it as a registered serial stream with a strobe.
// Optional feature macro: SCAN_CAPTURE_EN (adds the parallel capture word
// cap and its strobe cap_valid).
module mux_scan_sequencer #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned LAST     = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_scan_sequencer_if.slave  bus
);

    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_RUN   = 1'b1;
    localparam logic [23:0] CNT_MAX = 24'(TICK_DIV - 1);
    localparam logic [4:0]  SW_LAST = 5'(LAST);

    logic [0:0]  state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [4:0]  sw_q, sw_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        done_q, done_d;
`ifdef SCAN_CAPTURE_EN
    logic [31:0] cap_q, cap_d;
    logic        cap_valid_q, cap_valid_d;
`endif

    // Next-state logic: stop beats everything in RUN, including a sample
    // that would otherwise land on the same edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sw_d        = sw_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
`ifdef SCAN_CAPTURE_EN
        cap_d       = cap_q;
        cap_valid_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = 24'd0;
                sw_d  = 5'd0;
                if (bus.start && !bus.stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    sw_d    = 5'd0;
                    cnt_d   = 24'd0;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d       = 24'd0;
                    bit_out_d   = bus.bit_in;
                    bit_valid_d = 1'b1;
`ifdef SCAN_CAPTURE_EN
                    cap_d[sw_q] = bus.bit_in;
`endif
                    if (sw_q < SW_LAST) begin
                        sw_d = sw_q + 5'd1;
                    end else begin
                        // repeat_en only matters here, at the end of a scan
                        sw_d = 5'd0;
`ifdef SCAN_CAPTURE_EN
                        cap_valid_d = 1'b1;
`endif
                        if (!bus.repeat_en) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 24'd0;
                sw_d    = 5'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 24'd0;
            sw_q        <= 5'd0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef SCAN_CAPTURE_EN
            cap_q       <= 32'd0;
            cap_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sw_q        <= sw_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
`ifdef SCAN_CAPTURE_EN
            cap_q       <= cap_d;
            cap_valid_q <= cap_valid_d;
`endif
        end
    end

    assign bus.sw        = sw_q;
    assign bus.bit_out   = bit_out_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = done_q;
`ifdef SCAN_CAPTURE_EN
    assign bus.cap       = cap_q;
    assign bus.cap_valid = cap_valid_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: three instances with different dwell and
// scan lengths, a timeline model of the scan, and directed plus random
// stimulus driven from one process.
module tb_mux_scan_sequencer;

    localparam int N = 3;

    typedef struct {
        bit          run;
        int unsigned e;      // cycles spent scanning since the start
        logic [4:0]  sw;
        logic        bo;
        logic        v;
        logic        busy;
        logic        done;
        logic [31:0] cap;
        logic        capv;
    } mstate_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a [N];
    logic        stop_a  [N];
    logic        rep_a   [N];
    logic [31:0] pat_a   [N];
    logic [4:0]  sw_a    [N];
    logic        bo_a    [N];
    logic        v_a     [N];
    logic        busy_a  [N];
    logic        done_a  [N];
`ifdef SCAN_CAPTURE_EN
    logic [31:0] cap_a   [N];
    logic        capv_a  [N];
`endif

    mstate_t ms [N];
    int total = 0;
    int bad   = 0;

    function automatic int td_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 1;
    endfunction

    function automatic int last_of(int k);
        return (k == 1) ? 3 : 31;
    endfunction

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int TDG = (g == 0) ? 4 : (g == 1) ? 2 : 1;
        localparam int LSG = (g == 1) ? 3 : 31;
        mux_scan_sequencer_if bus ();
        mux_scan_sequencer #(.TICK_DIV(TDG), .LAST(LSG)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign bus.start     = start_a[g];
        assign bus.stop      = stop_a[g];
        assign bus.repeat_en = rep_a[g];
        assign bus.bit_in    = pat_a[g][bus.sw];
        assign sw_a[g]       = bus.sw;
        assign bo_a[g]       = bus.bit_out;
        assign v_a[g]        = bus.bit_valid;
        assign busy_a[g]     = bus.busy;
        assign done_a[g]     = bus.done;
`ifdef SCAN_CAPTURE_EN
        assign cap_a[g]      = bus.cap;
        assign capv_a[g]     = bus.cap_valid;
`endif
    end

    // Scan as a timeline: the index shown is elapsed/TICK_DIV modulo the
    // scan length, and a sample lands at the end of every dwell.
    function automatic mstate_t model_next(mstate_t s, int td, int last, logic r,
                                           logic st, logic sp, logic rep,
                                           logic [31:0] pat);
        mstate_t n = s;
        int idx;
        n.v    = 1'b0;
        n.done = 1'b0;
        n.capv = 1'b0;
        if (r) begin
            n.run = 1'b0;
            n.e   = 0;
            n.bo  = 1'b0;
            n.cap = 32'd0;
        end else if (!s.run) begin
            if (st && !sp) begin
                n.run = 1'b1;
                n.e   = 0;
            end
        end else if (sp) begin
            n.run = 1'b0;
        end else begin
            idx = int'(s.e / td) % (last + 1);
            if (int'(s.e % td) == td - 1) begin
                n.bo       = pat[idx];
                n.v        = 1'b1;
                n.cap[idx] = pat[idx];
                if (idx == last) begin
                    n.capv = 1'b1;
                    if (!rep) begin
                        n.run  = 1'b0;
                        n.done = 1'b1;
                    end
                end
            end
            n.e = s.e + 1;
        end
        n.busy = n.run;
        n.sw   = n.run ? 5'(int'(n.e / td) % (last + 1)) : 5'd0;
        return n;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t got=%0h want=%0h", nm, k, $time, got, want);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            chk("sw",        k, 32'(sw_a[k]),   32'(ms[k].sw));
            chk("bit_out",   k, 32'(bo_a[k]),   32'(ms[k].bo));
            chk("bit_valid", k, 32'(v_a[k]),    32'(ms[k].v));
            chk("busy",      k, 32'(busy_a[k]), 32'(ms[k].busy));
            chk("done",      k, 32'(done_a[k]), 32'(ms[k].done));
`ifdef SCAN_CAPTURE_EN
            chk("cap",       k, cap_a[k],        ms[k].cap);
            chk("cap_valid", k, 32'(capv_a[k]), 32'(ms[k].capv));
`endif
        end
    endtask

    // One clock: advance the model with the inputs the DUT samples on this
    // edge, then check every output on the falling edge.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            ms[k] = model_next(ms[k], td_of(k), last_of(k), rst, start_a[k],
                               stop_a[k], rep_a[k], pat_a[k]);
        end
        @(negedge clk);
        compare_all();
    endtask

    int          first_k [N];
    int          done_k  [N];
    int          nstb    [N];
    logic [31:0] rec     [N];
    int          ndone;
    logic [4:0]  sw_seen;

    task automatic clear_rec();
        for (int k = 0; k < N; k++) begin
            first_k[k] = 0;
            done_k[k]  = 0;
            nstb[k]    = 0;
            rec[k]     = 32'd0;
        end
    endtask

    task automatic record(int s);
        for (int k = 0; k < N; k++) begin
            if (v_a[k]) begin
                if (nstb[k] == 0) first_k[k] = s;
                if (nstb[k] < 32) rec[k][nstb[k]] = bo_a[k];
                nstb[k]++;
            end
            if (done_a[k] && done_k[k] == 0) begin
                done_k[k] = s;
                chk("done_busy", k, 32'(busy_a[k]), 32'd0);
                chk("done_sw",   k, 32'(sw_a[k]),   32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            start_a[k] = 1'b0;
            stop_a[k]  = 1'b0;
            rep_a[k]   = 1'b0;
            pat_a[k]   = 32'd0;
            ms[k]      = '{default: 0};
        end

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_sw",   0, 32'(sw_a[0]),   32'd0);
        chk("rst_busy", 0, 32'(busy_a[0]), 32'd0);
        chk("rst_bo",   0, 32'(bo_a[0]),   32'd0);
        chk("rst_v",    0, 32'(v_a[0]),    32'd0);
        chk("rst_done", 0, 32'(done_a[0]), 32'd0);

        // Full single scans on all three instances at once
        pat_a[0] = 32'hA5A5_0F0F;
        pat_a[1] = 32'h0000_0006;
        pat_a[2] = 32'hDEAD_BEEF;
        clear_rec();
        for (int k = 0; k < N; k++) start_a[k] = 1'b1;
        for (int s = 1; s <= 140; s++) begin
            tick();
            if (s == 1) for (int k = 0; k < N; k++) start_a[k] = 1'b0;
            if (s == 1) chk("start_busy", 0, 32'(busy_a[0]), 32'd1);
`ifdef SCAN_CAPTURE_EN
            if (done_a[2] && done_k[2] == 0) begin
                chk("cap_word",  2, cap_a[2],        32'hDEAD_BEEF);
                chk("cap_vdone", 2, 32'(capv_a[2]), 32'd1);
            end
            if (done_a[1] && done_k[1] == 0) chk("cap_above_last", 1, cap_a[1], 32'h6);
`endif
            record(s);
        end
        chk("first_strobe", 0, 32'(first_k[0]), 32'd5);
        chk("strobes",      0, 32'(nstb[0]),    32'd32);
        chk("bits",         0, rec[0],          32'hA5A5_0F0F);
        chk("done_at",      0, 32'(done_k[0]),  32'd129);
        chk("first_strobe", 1, 32'(first_k[1]), 32'd3);
        chk("strobes",      1, 32'(nstb[1]),    32'd4);
        chk("bits",         1, rec[1],          32'h6);
        chk("done_at",      1, 32'(done_k[1]),  32'd9);
        chk("first_strobe", 2, 32'(first_k[2]), 32'd2);
        chk("strobes",      2, 32'(nstb[2]),    32'd32);
        chk("bits",         2, rec[2],          32'hDEAD_BEEF);
        chk("done_at",      2, 32'(done_k[2]),  32'd33);

        // Repeat wrap on the short scan, then let it finish
        clear_rec();
        ndone      = 0;
        rep_a[1]   = 1'b1;
        start_a[1] = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            tick();
            if (s == 1) start_a[1] = 1'b0;
            if (done_a[1]) ndone++;
            record(s);
        end
        chk("rep_bits",    1, rec[1],           32'h66);
        chk("rep_strobes", 1, 32'(nstb[1]),     32'd9);
        chk("rep_nodone",  1, 32'(ndone),       32'd0);
        rep_a[1] = 1'b0;
        for (int s = 21; s <= 40; s++) begin
            tick();
            record(s);
        end
        chk("rep_end_at", 1, 32'(done_k[1]), 32'd25);

        // Stop and start together on the sampling cycle
        start_a[0] = 1'b1;
        for (int s = 1; s <= 12; s++) begin
            tick();
            if (s == 1) start_a[0] = 1'b0;
        end
        chk("pre_stop_sw", 0, 32'(sw_a[0]), 32'd2);
        stop_a[0]  = 1'b1;
        start_a[0] = 1'b1;
        tick();
        stop_a[0]  = 1'b0;
        start_a[0] = 1'b0;
        chk("stop_busy", 0, 32'(busy_a[0]), 32'd0);
        chk("stop_v",    0, 32'(v_a[0]),    32'd0);
        chk("stop_done", 0, 32'(done_a[0]), 32'd0);
        chk("stop_sw",   0, 32'(sw_a[0]),   32'd0);
        repeat (3) tick();
        chk("stop_stays_idle", 0, 32'(busy_a[0]), 32'd0);

        // Start pulse while busy does not restart the scan
        clear_rec();
        start_a[0] = 1'b1;
        for (int s = 1; s <= 140; s++) begin
            tick();
            if (s == 1)  start_a[0] = 1'b0;
            if (s == 30) begin
                sw_seen    = sw_a[0];
                start_a[0] = 1'b1;
            end
            if (s == 31) start_a[0] = 1'b0;
            if (s == 33) chk("busy_start_sw", 0, 32'(sw_a[0]), 32'd8);
            record(s);
        end
        chk("busy_start_at7",   0, 32'(sw_seen),    32'd7);
        chk("busy_start_stb",   0, 32'(nstb[0]),    32'd32);
        chk("busy_start_done",  0, 32'(done_k[0]),  32'd129);

        // Reset in the middle of a scan
        start_a[0] = 1'b1;
        for (int s = 1; s <= 10; s++) begin
            tick();
            if (s == 1) start_a[0] = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_sw",   0, 32'(sw_a[0]),   32'd0);
        chk("midrst_busy", 0, 32'(busy_a[0]), 32'd0);
        chk("midrst_v",    0, 32'(v_a[0]),    32'd0);
        chk("midrst_bo",   0, 32'(bo_a[0]),   32'd0);
        chk("midrst_done", 0, 32'(done_a[0]), 32'd0);

        // Random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 1499) == 0);
            for (int k = 0; k < N; k++) begin
                start_a[k] = ($urandom_range(0, 9) == 0);
                stop_a[k]  = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 39) == 0) rep_a[k] = ~rep_a[k];
                if ($urandom_range(0, 49) == 0) pat_a[k] = $urandom;
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
